// File: rtl/sparc_mul_pkg.sv
// ---------------------------------------------------------------------------
// sparc_mul_pkg
//   Shared definitions for the EXU multiply request/response sequencer.
//   - MUL_LAT_DEF : default cycles from multiplier accept to result on the bus
//   - CNT_W       : latency counter width (holds up to MUL_LAT-1 = 6)
//   - mul_state_e : sequencer state encoding
// ---------------------------------------------------------------------------
package sparc_mul_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no op held; new issue accepted
    ST_REQ  = 2'd1,  // presenting operands to the multiplier
    ST_WAIT = 2'd2,  // multiplier accepted; counting down latency
    ST_DONE = 2'd3   // result held for writeback
  } mul_state_e;

endpackage

// File: rtl/sparc_exu_mulreq.sv
// ---------------------------------------------------------------------------
// sparc_exu_mulreq
//   Sequences one multiply at a time between the EXU and a fixed-latency
//   multiplier, then holds the result until writeback takes it.
//
//   Parameters
//     MUL_LAT            cycles from mul_exu_ack to a valid mul_data_out (2..7)
//   Inputs
//     rclk, arst_l       clock / async active-low reset
//     ecl_mulreq_vld     issue strobe (taken in IDLE, or DONE with writeback ack)
//     ecl_mulreq_rs1/rs2 64-bit operands
//     ecl_mulreq_tid/rd  issuing thread / destination register
//     ecl_mulreq_flush   kill the in-flight op
//     mul_exu_ack        multiplier accepted the operands
//     mul_data_out       multiplier result bus
//     wb_mulres_ack      writeback consumed the result
//   Outputs (all registered except mulreq_busy)
//     exu_mul_input_vld, exu_mul_rs1_data, exu_mul_rs2_data   to multiplier
//     mulreq_busy                                             stall issue
//     mulres_vld, mulres_data, mulres_tid, mulres_rd          to writeback
// ---------------------------------------------------------------------------
module sparc_exu_mulreq
  import sparc_mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        ecl_mulreq_vld,
  input  logic [63:0] ecl_mulreq_rs1,
  input  logic [63:0] ecl_mulreq_rs2,
  input  logic [1:0]  ecl_mulreq_tid,
  input  logic [4:0]  ecl_mulreq_rd,
  input  logic        ecl_mulreq_flush,
  input  logic        mul_exu_ack,
  input  logic [63:0] mul_data_out,
  input  logic        wb_mulres_ack,
  output logic        exu_mul_input_vld,
  output logic [63:0] exu_mul_rs1_data,
  output logic [63:0] exu_mul_rs2_data,
  output logic        mulreq_busy,
  output logic        mulres_vld,
  output logic [63:0] mulres_data,
  output logic [1:0]  mulres_tid,
  output logic [4:0]  mulres_rd
);

  mul_state_e         r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_kill, w_kill;
  logic [1:0]         r_tid, w_tid;
  logic [4:0]         r_rd, w_rd;

  logic               w_in_vld;
  logic [63:0]        w_rs1, w_rs2;
  logic               w_res_vld;
  logic [63:0]        w_res_data;
  logic [1:0]         w_res_tid;
  logic [4:0]         w_res_rd;
  logic               w_accept;

  assign mulreq_busy = (r_state != ST_IDLE);

  // State register and all registered outputs.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      r_kill            <= 1'b0;
      r_tid             <= '0;
      r_rd              <= '0;
      exu_mul_input_vld <= 1'b0;
      exu_mul_rs1_data  <= '0;
      exu_mul_rs2_data  <= '0;
      mulres_vld        <= 1'b0;
      mulres_data       <= '0;
      mulres_tid        <= '0;
      mulres_rd         <= '0;
    end else begin
      r_state           <= w_state;
      r_cnt             <= w_cnt;
      r_kill            <= w_kill;
      r_tid             <= w_tid;
      r_rd              <= w_rd;
      exu_mul_input_vld <= w_in_vld;
      exu_mul_rs1_data  <= w_rs1;
      exu_mul_rs2_data  <= w_rs2;
      mulres_vld        <= w_res_vld;
      mulres_data       <= w_res_data;
      mulres_tid        <= w_res_tid;
      mulres_rd         <= w_res_rd;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_kill     = r_kill;
    w_tid      = r_tid;
    w_rd       = r_rd;
    w_in_vld   = exu_mul_input_vld;
    w_rs1      = exu_mul_rs1_data;
    w_rs2      = exu_mul_rs2_data;
    w_res_vld  = mulres_vld;
    w_res_data = mulres_data;
    w_res_tid  = mulres_tid;
    w_res_rd   = mulres_rd;
    w_accept   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_accept = ecl_mulreq_vld;
      end

      ST_REQ: begin
        if (mul_exu_ack) begin
          // A flush landing on the accept cycle cannot recall the op from
          // the multiplier, so it becomes a kill that discards the result.
          w_state  = ST_WAIT;
          w_in_vld = 1'b0;
          w_cnt    = CNT_W'(MUL_LAT - 1);
          w_kill   = ecl_mulreq_flush;
        end else if (ecl_mulreq_flush) begin
          w_state  = ST_IDLE;
          w_in_vld = 1'b0;
        end
      end

      ST_WAIT: begin
        if (r_cnt == '0) begin
          if (r_kill || ecl_mulreq_flush) begin
            w_state = ST_IDLE;
            w_kill  = 1'b0;
          end else begin
            w_state    = ST_DONE;
            w_res_vld  = 1'b1;
            w_res_data = mul_data_out;
            w_res_tid  = r_tid;
            w_res_rd   = r_rd;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
          if (ecl_mulreq_flush) w_kill = 1'b1;
        end
      end

      ST_DONE: begin
        if (ecl_mulreq_flush) begin
          w_state   = ST_IDLE;
          w_res_vld = 1'b0;
        end else if (wb_mulres_ack) begin
          // Retiring the result frees the slot this cycle, so an issue in
          // the same cycle goes straight back to REQ with no idle bubble.
          w_state   = ST_IDLE;
          w_res_vld = 1'b0;
          w_accept  = ecl_mulreq_vld;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_state  = ST_REQ;
      w_in_vld = 1'b1;
      w_rs1    = ecl_mulreq_rs1;
      w_rs2    = ecl_mulreq_rs2;
      w_tid    = ecl_mulreq_tid;
      w_rd     = ecl_mulreq_rd;
      w_kill   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sparc_exu_mulreq.sv
module tb_sparc_exu_mulreq;

  localparam int L = 5;

  logic        rclk = 1'b0;
  logic        arst_l;
  logic        ecl_mulreq_vld;
  logic [63:0] ecl_mulreq_rs1, ecl_mulreq_rs2;
  logic [1:0]  ecl_mulreq_tid;
  logic [4:0]  ecl_mulreq_rd;
  logic        ecl_mulreq_flush;
  logic        mul_exu_ack;
  logic [63:0] mul_data_out;
  logic        wb_mulres_ack;
  logic        exu_mul_input_vld;
  logic [63:0] exu_mul_rs1_data, exu_mul_rs2_data;
  logic        mulreq_busy;
  logic        mulres_vld;
  logic [63:0] mulres_data;
  logic [1:0]  mulres_tid;
  logic [4:0]  mulres_rd;

  int total = 0;
  int bad   = 0;

  sparc_exu_mulreq #(.MUL_LAT(L)) dut (
    .rclk(rclk), .arst_l(arst_l),
    .ecl_mulreq_vld(ecl_mulreq_vld), .ecl_mulreq_rs1(ecl_mulreq_rs1),
    .ecl_mulreq_rs2(ecl_mulreq_rs2), .ecl_mulreq_tid(ecl_mulreq_tid),
    .ecl_mulreq_rd(ecl_mulreq_rd), .ecl_mulreq_flush(ecl_mulreq_flush),
    .mul_exu_ack(mul_exu_ack), .mul_data_out(mul_data_out),
    .wb_mulres_ack(wb_mulres_ack),
    .exu_mul_input_vld(exu_mul_input_vld), .exu_mul_rs1_data(exu_mul_rs1_data),
    .exu_mul_rs2_data(exu_mul_rs2_data), .mulreq_busy(mulreq_busy),
    .mulres_vld(mulres_vld), .mulres_data(mulres_data),
    .mulres_tid(mulres_tid), .mulres_rd(mulres_rd)
  );

  always #5 rclk = ~rclk;

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ivld"}, exu_mul_input_vld, 0);
    chk({tag, "_rs1"},  exu_mul_rs1_data, 0);
    chk({tag, "_rs2"},  exu_mul_rs2_data, 0);
    chk({tag, "_busy"}, mulreq_busy, 0);
    chk({tag, "_rvld"}, mulres_vld, 0);
    chk({tag, "_rdat"}, mulres_data, 0);
    chk({tag, "_rtid"}, mulres_tid, 0);
    chk({tag, "_rrd"},  mulres_rd, 0);
  endtask

  // Present one issue strobe; afterwards the operand inputs carry junk so a
  // late or repeated capture would be visible.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] t, input logic [4:0] r);
    ecl_mulreq_vld = 1'b1;
    ecl_mulreq_rs1 = a; ecl_mulreq_rs2 = b;
    ecl_mulreq_tid = t; ecl_mulreq_rd  = r;
    tick;
    ecl_mulreq_vld = 1'b0;
    ecl_mulreq_rs1 = r64(); ecl_mulreq_rs2 = r64();
    ecl_mulreq_tid = 2'($urandom); ecl_mulreq_rd = 5'($urandom);
    chk("req_ivld", exu_mul_input_vld, 1);
    chk("req_rs1", exu_mul_rs1_data, a);
    chk("req_rs2", exu_mul_rs2_data, b);
    chk("req_busy", mulreq_busy, 1);
  endtask

  // Multiplier side plus writeback for an op already in REQ.
  //   d   : cycles ack is withheld
  //   fl  : -1 none, 0 flush with ack, k>0 flush k cycles after ack
  //   wbd : >=0 writeback delay, -1 flush in DONE, -2 leave result pending
  //   spur: pulse an ignored issue strobe while waiting
  task automatic finish(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] t, input logic [4:0] r,
                        input int d, input int fl, input int wbd, input bit spur);
    logic [63:0] p;
    p = a * b;
    for (int i = 0; i < d; i++) begin
      tick;
      chk("hold_ivld", exu_mul_input_vld, 1);
      chk("hold_rs1", exu_mul_rs1_data, a);
      chk("hold_rs2", exu_mul_rs2_data, b);
      chk("hold_busy", mulreq_busy, 1);
    end
    mul_exu_ack = 1'b1;
    if (fl == 0) ecl_mulreq_flush = 1'b1;
    tick;
    mul_exu_ack = 1'b0;
    ecl_mulreq_flush = 1'b0;
    for (int k = 1; k <= L; k++) begin
      if (fl == k) ecl_mulreq_flush = 1'b1;
      if (spur && k == 2) begin
        ecl_mulreq_vld = 1'b1;
        ecl_mulreq_rs1 = r64(); ecl_mulreq_rs2 = r64();
      end
      mul_data_out = (k == L) ? p : r64();
      chk("wait_rvld", mulres_vld, 0);
      chk("wait_ivld", exu_mul_input_vld, 0);
      chk("wait_busy", mulreq_busy, 1);
      chk("wait_rs1", exu_mul_rs1_data, a);
      tick;
      ecl_mulreq_flush = 1'b0;
      ecl_mulreq_vld = 1'b0;
    end
    mul_data_out = r64();
    if (fl >= 0) begin
      chk("kill_rvld", mulres_vld, 0);
      chk("kill_busy", mulreq_busy, 0);
    end else begin
      chk("res_vld", mulres_vld, 1);
      chk("res_data", mulres_data, p);
      chk("res_tid", mulres_tid, t);
      chk("res_rd", mulres_rd, r);
      for (int w = 0; w < wbd; w++) begin
        tick;
        chk("res_hold_vld", mulres_vld, 1);
        chk("res_hold_data", mulres_data, p);
        chk("res_hold_busy", mulreq_busy, 1);
      end
      if (wbd == -1) begin
        ecl_mulreq_flush = 1'b1;
        tick;
        ecl_mulreq_flush = 1'b0;
        chk("dflush_rvld", mulres_vld, 0);
        chk("dflush_busy", mulreq_busy, 0);
      end else if (wbd >= 0) begin
        wb_mulres_ack = 1'b1;
        tick;
        wb_mulres_ack = 1'b0;
        chk("wb_rvld", mulres_vld, 0);
        chk("wb_busy", mulreq_busy, 0);
      end
    end
  endtask

  initial begin
    logic [63:0] a, b;
    logic [1:0]  t;
    logic [4:0]  r;
    arst_l = 1'b0;
    ecl_mulreq_vld = 1'b0; ecl_mulreq_rs1 = '0; ecl_mulreq_rs2 = '0;
    ecl_mulreq_tid = '0; ecl_mulreq_rd = '0; ecl_mulreq_flush = 1'b0;
    mul_exu_ack = 1'b0; mul_data_out = '0; wb_mulres_ack = 1'b0;
    #1;
    chk_all_zero("rst");
    tick; tick;
    arst_l = 1'b1;
    tick;
    chk_all_zero("post_rst");

    // Basic op: 3*5, ack one cycle after REQ entry.
    issue(64'd3, 64'd5, 2'd2, 5'd17);
    finish(64'd3, 64'd5, 2'd2, 5'd17, 1, -1, 0, 1'b0);

    // Ack withheld 4 cycles, result held 2 cycles before writeback.
    issue(64'h1234_5678_9abc_def0, 64'd11, 2'd1, 5'd3);
    finish(64'h1234_5678_9abc_def0, 64'd11, 2'd1, 5'd3, 4, -1, 2, 1'b0);

    // Flush two cycles after ack, then a fresh op must still work.
    issue(64'd6, 64'd7, 2'd3, 5'd9);
    finish(64'd6, 64'd7, 2'd3, 5'd9, 0, 2, 0, 1'b0);
    issue(64'd100, 64'd200, 2'd0, 5'd31);
    finish(64'd100, 64'd200, 2'd0, 5'd31, 2, -1, 0, 1'b0);

    // Flush coincident with ack behaves as a kill.
    issue(64'd8, 64'd9, 2'd1, 5'd1);
    finish(64'd8, 64'd9, 2'd1, 5'd1, 1, 0, 0, 1'b0);

    // Flush in REQ without ack drops the request next cycle.
    issue(64'd2, 64'd2, 2'd2, 5'd2);
    ecl_mulreq_flush = 1'b1;
    tick;
    ecl_mulreq_flush = 1'b0;
    chk("rflush_ivld", exu_mul_input_vld, 0);
    chk("rflush_busy", mulreq_busy, 0);

    // Flush while result is pending.
    issue(64'd13, 64'd17, 2'd3, 5'd20);
    finish(64'd13, 64'd17, 2'd3, 5'd20, 0, -1, -1, 1'b0);

    // Spurious issue during WAIT is ignored.
    issue(64'd21, 64'd22, 2'd1, 5'd12);
    finish(64'd21, 64'd22, 2'd1, 5'd12, 1, -1, 1, 1'b1);

    // Writeback ack and new issue together: straight back to REQ.
    issue(64'd4, 64'd4, 2'd0, 5'd5);
    finish(64'd4, 64'd4, 2'd0, 5'd5, 0, -1, -2, 1'b0);
    wb_mulres_ack = 1'b1;
    ecl_mulreq_vld = 1'b1;
    ecl_mulreq_rs1 = 64'd7; ecl_mulreq_rs2 = 64'd9;
    ecl_mulreq_tid = 2'd3; ecl_mulreq_rd = 5'd30;
    tick;
    wb_mulres_ack = 1'b0;
    ecl_mulreq_vld = 1'b0;
    chk("b2b_ivld", exu_mul_input_vld, 1);
    chk("b2b_rs1", exu_mul_rs1_data, 64'd7);
    chk("b2b_rs2", exu_mul_rs2_data, 64'd9);
    chk("b2b_rvld", mulres_vld, 0);
    chk("b2b_busy", mulreq_busy, 1);
    finish(64'd7, 64'd9, 2'd3, 5'd30, 1, -1, 0, 1'b0);

    // Reset during WAIT: outputs clear at once, no late result.
    issue(64'd5, 64'd5, 2'd2, 5'd7);
    mul_exu_ack = 1'b1;
    tick;
    mul_exu_ack = 1'b0;
    tick;
    arst_l = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick;
    arst_l = 1'b1;
    for (int k = 0; k < L + 2; k++) begin
      mul_data_out = 64'd25;
      chk("midrst_rvld", mulres_vld, 0);
      chk("midrst_busy", mulreq_busy, 0);
      tick;
    end

    // Random traffic.
    for (int n = 0; n < 25; n++) begin
      int fl, wbd;
      a = r64(); b = r64();
      t = 2'($urandom); r = 5'($urandom);
      fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L)) : -1;
      wbd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 2));
      issue(a, b, t, r);
      finish(a, b, t, r, int'($urandom_range(0, 3)), fl, wbd, 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
